// File: rtl/alu_arbiter_if.sv
// Requester-side bundle for alu_arbiter: operation request channel and result response channel.
// Requester i owns slice i of every packed per-requester bus.
interface alu_arbiter_if #(
  parameter int NREQ = 2,
  parameter int W    = 18
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [3*NREQ-1:0] req_op;
  logic [W*NREQ-1:0] req_a;
  logic [W*NREQ-1:0] req_b;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [W-1:0]      rsp_result;
  logic [3:0]        rsp_flags;
  logic              rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one combinational ALU between NREQ requesters.
// One operation in flight: IDLE (grant + latch operands) -> EXEC (capture ALU) -> RESP (hold until accepted).
module alu_arbiter #(
  parameter int NREQ = 2,
  parameter int W    = 18
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [2:0]    alu_ctrl,
  input  logic [W-1:0]  alu_result,
  input  logic [3:0]    alu_flags
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef logic [IDXW-1:0] idx_t;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t          state, state_nxt;
  idx_t            ptr, winner, pick;
  logic            found;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] winner_onehot;
  logic [2:0]      pick_op;
  logic [W-1:0]    pick_a, pick_b;
  logic            pick_illegal, pick_div_zero;
  logic            illegal_q, div_zero_q;

  // Search from the pointer upward with wrap-around; first pending requester wins.
  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin : rr_pick
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = ptr;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        pick  = idx_t'(idx);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (state == IDLE && found) grant[pick] = 1'b1;
    winner_onehot = '0;
    winner_onehot[winner] = 1'b1;
  end

  assign bus.req_ready = grant;

  always_comb begin
    pick_op       = bus.req_op[int'(pick)*3 +: 3];
    pick_a        = bus.req_a[int'(pick)*W +: W];
    pick_b        = bus.req_b[int'(pick)*W +: W];
    pick_illegal  = (pick_op > 3'b100);
    pick_div_zero = (pick_op == 3'b011) && (pick_b == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready[winner]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr            <= '0;
      winner         <= '0;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_ctrl       <= '0;
      illegal_q      <= 1'b0;
      div_zero_q     <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_flags  <= '0;
      bus.rsp_err    <= 1'b0;
      bus.rsp_valid  <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          winner      <= pick;
          ptr         <= (int'(pick) == NREQ - 1) ? idx_t'(0) : pick + idx_t'(1);
          // Illegal codes are neutralised so the ALU sees a harmless 0 + 0.
          alu_ctrl    <= pick_illegal ? 3'b000 : pick_op;
          alu_a       <= pick_illegal ? '0 : pick_a;
          alu_b       <= pick_illegal ? '0 : pick_b;
          illegal_q   <= pick_illegal;
          div_zero_q  <= pick_div_zero;
          bus.rsp_err <= pick_illegal | pick_div_zero;
        end
        EXEC: begin
          if (div_zero_q)     bus.rsp_result <= '1;
          else if (illegal_q) bus.rsp_result <= '0;
          else                bus.rsp_result <= alu_result;
          bus.rsp_flags <= div_zero_q ? 4'b0000 : alu_flags;
          bus.rsp_valid <= winner_onehot;
        end
        RESP: if (bus.rsp_ready[winner]) bus.rsp_valid <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: behavioural ALU model, expected-response queue, decoupled monitor.
// Expected results are hand-computed constants pushed at issue time.
module tb_alu_arbiter;
  localparam int NREQ = 2;
  localparam int W    = 18;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_PSA = 3'b100;
  localparam logic [2:0] OP_BAD = 3'b110;

  typedef struct {
    int           idx;
    logic [W-1:0] res;
    logic [3:0]   flags;
    logic         err;
    bit           chk_flags;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [2:0]   alu_ctrl;
  logic [3:0]   alu_flags;

  alu_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  alu_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_flags  (alu_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: carry is "no borrow" for subtraction, signed overflow on add/sub only.
  logic [W:0] wide;
  logic       cflag, vflag;
  always_comb begin
    wide       = '0;
    alu_result = '0;
    cflag      = 1'b0;
    vflag      = 1'b0;
    case (alu_ctrl)
      OP_ADD: begin
        wide       = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = wide[W-1:0];
        cflag      = wide[W];
        vflag      = (alu_a[W-1] == alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
      end
      OP_SUB: begin
        wide       = {1'b0, alu_a} + {1'b0, ~alu_b} + (W+1)'(1);
        alu_result = wide[W-1:0];
        cflag      = wide[W];
        vflag      = (alu_a[W-1] != alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
      end
      OP_MUL: alu_result = W'(alu_a * alu_b);
      OP_DIV: alu_result = (alu_b != '0) ? alu_a / alu_b : '1;
      OP_PSA: alu_result = alu_a;
      default: alu_result = '0;
    endcase
    alu_flags = {alu_result[W-1], alu_result == '0, cflag, vflag};
  end

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Monitor: every accepted response is compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (bus.rsp_valid & bus.rsp_ready) != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 32'(bus.rsp_valid), 32'h0);
        end else begin
          e = sb.pop_front();
          check("rsp_owner",  32'(bus.rsp_valid),  32'(1) << e.idx);
          check("rsp_result", 32'(bus.rsp_result), 32'(e.res));
          check("rsp_err",    32'(bus.rsp_err),    32'(e.err));
          if (e.chk_flags) check("rsp_flags", 32'(bus.rsp_flags), 32'(e.flags));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic issue(input int i, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push, input logic [W-1:0] er, input logic [3:0] ef, input logic ee,
                       input bit cf);
    bit got;
    got = 1'b0;
    bus.req_op[i*3 +: 3] = op;
    bus.req_a[i*W +: W]  = a;
    bus.req_b[i*W +: W]  = b;
    bus.req_valid[i]     = 1'b1;
    if (push) sb.push_back('{i, er, ef, ee, cf});
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (bus.req_ready[i]) got = 1'b1;
    end
    check("grant_seen", 32'(got), 32'h1);
    @(posedge clk); #1;
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp();
    bit got;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if ((bus.rsp_valid & bus.rsp_ready) != '0) got = 1'b1;
    end
    check("rsp_seen", 32'(got), 32'h1);
    @(posedge clk); #1;
  endtask

  task automatic wait_valid();
    bit got;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (bus.rsp_valid != '0) got = 1'b1;
    end
    check("valid_seen", 32'(got), 32'h1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  logic [NREQ-1:0] gnt[4];
  int              gcyc[4];
  int              gcnt;
  logic [NREQ-1:0] exp_gnt[4];

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '1;
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", 32'(bus.rsp_valid),  32'h0);
    check("rst_req_ready", 32'(bus.req_ready),  32'h0);
    check("rst_alu_a",     32'(alu_a),          32'h0);
    check("rst_alu_ctrl",  32'(alu_ctrl),       32'h0);
    check("rst_result",    32'(bus.rsp_result), 32'h0);
    check("rst_err",       32'(bus.rsp_err),    32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1. Single add with latency check
    issue(0, OP_ADD, 18'h00005, 18'h00003, 1'b1, 18'h00008, 4'b0000, 1'b0, 1'b1);
    @(negedge clk);
    check("lat_n1_valid", 32'(bus.rsp_valid), 32'h0);
    check("exec_alu_a",   32'(alu_a),         32'h5);
    check("exec_alu_b",   32'(alu_b),         32'h3);
    @(negedge clk);
    check("lat_n2_valid", 32'(bus.rsp_valid), 32'h1);
    @(posedge clk); #1;

    // 2. Contention from pointer 0 with continuous valids
    pulse_reset();
    bus.req_op  = {OP_MUL, OP_ADD};
    bus.req_a   = {18'h00003, 18'h00011};
    bus.req_b   = {18'h00004, 18'h00022};
    bus.req_valid = 2'b11;
    gcnt = 0;
    for (int c = 0; c < 40 && gcnt < 4; c++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        gnt[gcnt]  = bus.req_ready;
        gcyc[gcnt] = c;
        if (bus.req_ready == 2'b01) sb.push_back('{0, 18'h00033, 4'b0000, 1'b0, 1'b1});
        else                        sb.push_back('{1, 18'h0000C, 4'b0000, 1'b0, 1'b1});
        gcnt++;
      end
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    check("contention_grants", 32'(gcnt), 32'h4);
    for (int k = 0; k < 4 && k < gcnt; k++) begin
      check("contention_order", 32'(gnt[k]), 32'(exp_gnt[k]));
      if (k > 0) check("contention_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'h3);
    end
    wait_rsp();

    // 3. Backpressure on a subtract; other rsp_ready bit is ignored, no new grant
    bus.rsp_ready = 2'b00;
    issue(0, OP_SUB, 18'h00003, 18'h00005, 1'b1, 18'h3FFFE, 4'b1000, 1'b0, 1'b1);
    bus.req_op[5:3]    = OP_ADD;
    bus.req_a[35:18]   = 18'h00001;
    bus.req_b[35:18]   = 18'h00001;
    bus.req_valid[1]   = 1'b1;
    bus.rsp_ready      = 2'b10;
    wait_valid();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_valid",  32'(bus.rsp_valid),    32'h1);
      check("hold_result", 32'(bus.rsp_result),   32'h3FFFE);
      check("hold_neg",    32'(bus.rsp_flags[3]), 32'h1);
      check("hold_nogrant", 32'(bus.req_ready),   32'h0);
    end
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    bus.rsp_ready    = 2'b01;
    wait_rsp();
    bus.rsp_ready = 2'b11;

    // 4. Error cases and a legal divide
    issue(1, OP_BAD, 18'h00123, 18'h00456, 1'b1, 18'h00000, 4'b0000, 1'b1, 1'b0);
    @(negedge clk);
    check("bad_alu_ctrl", 32'(alu_ctrl), 32'h0);
    check("bad_alu_a",    32'(alu_a),    32'h0);
    check("bad_alu_b",    32'(alu_b),    32'h0);
    wait_rsp();
    issue(0, OP_DIV, 18'h00010, 18'h00000, 1'b1, 18'h3FFFF, 4'b0000, 1'b1, 1'b1);
    wait_rsp();
    issue(1, OP_DIV, 18'h00010, 18'h00004, 1'b1, 18'h00004, 4'b0000, 1'b0, 1'b1);
    wait_rsp();

    // 5. Signed overflow on add, and pass-A
    issue(0, OP_ADD, 18'h1FFFF, 18'h00001, 1'b1, 18'h20000, 4'b1001, 1'b0, 1'b1);
    wait_rsp();
    issue(1, OP_PSA, 18'h2ABCD, 18'h00007, 1'b1, 18'h2ABCD, 4'b1000, 1'b0, 1'b1);
    wait_rsp();

    // 6. Reset during EXEC, then during RESP; pointer returns to 0
    issue(1, OP_ADD, 18'h00001, 18'h00001, 1'b0, '0, '0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("rst_exec_valid",  32'(bus.rsp_valid),  32'h0);
    check("rst_exec_alu_a",  32'(alu_a),          32'h0);
    check("rst_exec_result", 32'(bus.rsp_result), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rsp_ready = 2'b00;
    issue(0, OP_ADD, 18'h00002, 18'h00002, 1'b0, '0, '0, 1'b0, 1'b0);
    wait_valid();
    rst = 1'b1;
    #1;
    check("rst_resp_valid",  32'(bus.rsp_valid),  32'h0);
    check("rst_resp_result", 32'(bus.rsp_result), 32'h0);
    check("rst_resp_flags",  32'(bus.rsp_flags),  32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rsp_ready = 2'b11;
    bus.req_valid = 2'b11;
    @(negedge clk);
    check("post_rst_grant", 32'(bus.req_ready), 32'h1);
    bus.req_valid = 2'b00;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst_quiet", 32'(bus.rsp_valid), 32'h0);
    end

    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
